// File: rtl/ac2_accum_if.sv
// Handshake bundle for ac2_accum: partial-word input stream, result output stream
// and the AC2 term-counter strobes.
interface ac2_accum_if #(
  parameter int DW = 16,
  parameter int AW = 24
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          ac2_cnt;
  logic          cnt_clear;
  logic          sat_flag;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ac2_cnt, cnt_clear, sat_flag
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ac2_cnt, cnt_clear, sat_flag
  );
endinterface

// File: rtl/ac2_accum.sv
// Accumulates PW signed partial words into one AW-bit signed result (IDLE/ACC/HOLD).
// Define AC2_SAT_EN for saturating adds with a sticky sat_flag; otherwise adds wrap.
module ac2_accum #(
  parameter int PW = 4,
  parameter int DW = 16,
  parameter int AW = 24
) (
  input logic        clk,
  input logic        rst_n,
  ac2_accum_if.slave bus
);
  localparam int CW = $clog2(PW) + 1;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic                 start_ok;
  logic                 accept;
  logic                 last_word;

  // A start is honoured in IDLE, in ACC (restart) and in HOLD only alongside the result handshake.
  assign start_ok  = rst_n && bus.start &&
                     ((state == IDLE) || (state == ACC) || ((state == HOLD) && bus.out_ready));
  assign accept    = (state == ACC) && bus.in_valid && !bus.start;
  assign last_word = accept && (count == CW'(PW - 1));

`ifdef AC2_SAT_EN
  logic signed [AW:0] sum_wide;
  logic               clip;
  logic               sat_q;

  assign sum_wide = {acc[AW-1], acc} + {{(AW + 1 - DW){bus.in_data[DW-1]}}, bus.in_data};
  assign clip     = (sum_wide[AW] != sum_wide[AW-1]);

  always_comb begin
    acc_next = sum_wide[AW-1:0];
    if (clip) begin
      acc_next = sum_wide[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (start_ok) begin
      sat_q <= 1'b0;
    end else if (accept && clip) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.sat_flag = sat_q;
`else
  assign acc_next     = acc + {{(AW - DW){bus.in_data[DW-1]}}, bus.in_data};
  assign bus.sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
    end else if (start_ok) begin
      state <= ACC;
      acc   <= '0;
      count <= '0;
    end else begin
      unique case (state)
        ACC: begin
          if (accept) begin
            acc <= acc_next;
            if (last_word) begin
              count <= '0;
              state <= HOLD;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // The accumulator itself is the result; it is frozen while in HOLD.
  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = acc;
  assign bus.ac2_cnt   = accept;
  assign bus.cnt_clear = start_ok;
endmodule

// File: tb/tb_ac2_accum.sv
// Directed self-checking bench for ac2_accum: a default-width instance plus an AW=17
// instance driven in lock-step to exercise overflow (saturate or wrap per AC2_SAT_EN).
module tb_ac2_accum;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;

`ifdef AC2_SAT_EN
  localparam logic signed [63:0] EXP_B_SUM  = 65535;
  localparam logic signed [63:0] EXP_B_FLAG = 1;
`else
  localparam logic signed [63:0] EXP_B_SUM  = -4;
  localparam logic signed [63:0] EXP_B_FLAG = 0;
`endif

  ac2_accum_if #(.DW(16), .AW(24)) bus_a ();
  ac2_accum_if #(.DW(16), .AW(17)) bus_b ();

  ac2_accum #(.PW(4), .DW(16), .AW(24)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  ac2_accum #(.PW(4), .DW(16), .AW(17)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic s, input logic v, input logic signed [15:0] d,
                                input logic r);
    bus_a.start = s; bus_a.in_valid = v; bus_a.in_data = d; bus_a.out_ready = r;
    bus_b.start = s; bus_b.in_valid = v; bus_b.in_data = d; bus_b.out_ready = r;
    #1;
  endtask

  task automatic check_output(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic push_word(input logic signed [15:0] d);
    apply_stimulus(1'b0, 1'b1, d, 1'b0);
    check_output("in_ready_acc", bus_a.in_ready, 1);
    check_output("ac2_cnt_accept", bus_a.ac2_cnt, 1);
    check_output("out_valid_early", bus_a.out_valid, 0);
    tick();
  endtask

  task automatic begin_acc();
    apply_stimulus(1'b1, 1'b0, 16'sd0, 1'b0);
    check_output("cnt_clear_start", bus_a.cnt_clear, 1);
    check_output("ac2_cnt_on_start", bus_a.ac2_cnt, 0);
    tick();
  endtask

  initial begin
    logic        gap_valid [8];
    logic signed [15:0] gap_data [8];
    logic signed [15:0] ovf_word;

    rst_n = 1'b0;
    apply_stimulus(1'b1, 1'b1, 16'sd5, 1'b1);
    #2;
    check_output("rst_in_ready", bus_a.in_ready, 0);
    check_output("rst_out_valid", bus_a.out_valid, 0);
    check_output("rst_out_data", $signed(bus_a.out_data), 0);
    check_output("rst_ac2_cnt", bus_a.ac2_cnt, 0);
    check_output("rst_cnt_clear", bus_a.cnt_clear, 0);
    check_output("rst_sat_flag", bus_a.sat_flag, 0);
    tick();
    tick();
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, 16'sd0, 1'b0);
    check_output("idle_in_ready", bus_a.in_ready, 0);
    check_output("idle_out_valid", bus_a.out_valid, 0);
    tick();

    $display("[TB] basic sum 1+2+3+4");
    begin_acc();
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    check_output("sum_basic_valid", bus_a.out_valid, 1);
    check_output("sum_basic", $signed(bus_a.out_data), 10);

    $display("[TB] hold under backpressure");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(i == 2, 1'b1, 16'sd99, 1'b0);
      check_output("hold_in_ready", bus_a.in_ready, 0);
      check_output("hold_out_valid", bus_a.out_valid, 1);
      check_output("hold_out_data", $signed(bus_a.out_data), 10);
      check_output("hold_ac2_cnt", bus_a.ac2_cnt, 0);
      check_output("hold_start_ignored", bus_a.cnt_clear, 0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 16'sd0, 1'b1);
    check_output("hold_handshake_valid", bus_a.out_valid, 1);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'sd0, 1'b0);
    check_output("after_hs_out_valid", bus_a.out_valid, 0);
    check_output("after_hs_in_ready", bus_a.in_ready, 0);
    tick();

    $display("[TB] signed words with gaps");
    gap_valid = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    gap_data  = '{-16'sd5, 16'sd77, 16'sd3, -16'sd9, 16'sd11, -16'sd7, 16'sd1, 16'sd2};
    begin_acc();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, gap_valid[i], gap_data[i], 1'b0);
      check_output("gap_ac2_cnt", bus_a.ac2_cnt, gap_valid[i]);
      tick();
    end
    check_output("gap_sum_valid", bus_a.out_valid, 1);
    check_output("gap_sum", $signed(bus_a.out_data), -7);

    $display("[TB] handshake with start goes straight to ACC");
    apply_stimulus(1'b1, 1'b0, 16'sd0, 1'b1);
    check_output("hs_start_cnt_clear", bus_a.cnt_clear, 1);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'sd0, 1'b0);
    check_output("hs_start_in_ready", bus_a.in_ready, 1);
    check_output("hs_start_out_valid", bus_a.out_valid, 0);

    $display("[TB] restart mid-accumulation");
    push_word(16'sd5);
    push_word(16'sd6);
    apply_stimulus(1'b1, 1'b1, 16'sd100, 1'b0);
    check_output("restart_in_ready", bus_a.in_ready, 1);
    check_output("restart_ac2_cnt", bus_a.ac2_cnt, 0);
    check_output("restart_cnt_clear", bus_a.cnt_clear, 1);
    tick();
    for (int i = 0; i < 4; i++) push_word(16'sd1);
    check_output("restart_sum", $signed(bus_a.out_data), 4);
    apply_stimulus(1'b0, 1'b0, 16'sd0, 1'b1);
    tick();

    $display("[TB] reset while holding a result");
    begin_acc();
    for (int i = 0; i < 4; i++) push_word(16'sd7);
    apply_stimulus(1'b0, 1'b0, 16'sd0, 1'b0);
    check_output("pre_rst_sum", $signed(bus_a.out_data), 28);
    rst_n = 1'b0;
    #1;
    check_output("rst_hold_out_valid", bus_a.out_valid, 0);
    check_output("rst_hold_cnt_clear", bus_a.cnt_clear, 0);
    check_output("rst_hold_out_data", $signed(bus_a.out_data), 0);
    tick();
    rst_n = 1'b1;
    tick();
    begin_acc();
    push_word(16'sd100);
    push_word(-16'sd200);
    push_word(16'sd300);
    push_word(-16'sd400);
    check_output("post_rst_sum", $signed(bus_a.out_data), -200);
    check_output("post_rst_sum_b", $signed(bus_b.out_data), -200);
    apply_stimulus(1'b0, 1'b0, 16'sd0, 1'b1);
    tick();

    $display("[TB] overflow on the AW=17 instance");
    ovf_word = 16'sd32767;
    begin_acc();
    for (int i = 0; i < 4; i++) push_word(ovf_word);
    check_output("ovf_sum_a", $signed(bus_a.out_data), 131068);
    check_output("ovf_flag_a", bus_a.sat_flag, 0);
    check_output("ovf_sum_b", $signed(bus_b.out_data), EXP_B_SUM);
    check_output("ovf_flag_b", bus_b.sat_flag, EXP_B_FLAG);
    apply_stimulus(1'b1, 1'b0, 16'sd0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'sd0, 1'b0);
    check_output("flag_cleared_b", bus_b.sat_flag, 0);
    check_output("new_acc_in_ready_b", bus_b.in_ready, 1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
